regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32x32 register file. Two writeback sources share the single register-file write port: source A is the single-cycle pipeline writeback, and source B is the long-latency unit writeback (load/multi-cycle). The block registers the winning write onto the regfile `i_rd_*` inputs. It also keeps a per-register busy scoreboard for B-side operations, so the decode stage can stall on RAW hazards.

---
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with B-side busy scoreboard
//
// Purpose:
//   Two writeback sources share one register-file write port. Source A is the
//   single-cycle pipeline writeback and source B is the long-latency unit
//   writeback. The winning write is registered onto o_rd_*. A per-register
//   busy scoreboard tracks outstanding B operations so decode can stall on
//   RAW hazards.
//
// Configuration:
//   WBARB_AGING_EN  defined   : B is forced to win after MAX_WAIT refused cycles.
//   WBARB_AGING_EN  undefined : strict A priority; B may starve.
//
// Ports:
//   i_clk, i_rst                   clock, asynchronous active-low reset
//   i_a_valid/i_a_rd/i_a_data      source A write request
//   o_a_ready                      source A accepted this cycle
//   i_b_valid/i_b_rd/i_b_data      source B write request
//   o_b_ready                      source B accepted this cycle
//   i_issue_valid/i_issue_rd       B-unit operation issued to rd
//   i_rs1_addr/i_rs2_addr          decode source registers
//   o_rs1_busy/o_rs2_busy          scoreboard lookups (combinational)
//   o_busy_vec                     full scoreboard, bit 0 always 0
//   o_rd_addr/o_rd_data/o_rd_wren  registered regfile write port

module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_valid,
  input  logic [4:0]  i_a_rd,
  input  logic [31:0] i_a_data,
  output logic        o_a_ready,
  input  logic        i_b_valid,
  input  logic [4:0]  i_b_rd,
  input  logic [31:0] i_b_data,
  output logic        o_b_ready,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic [31:0] o_busy_vec,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren
);

  logic        b_force;
  logic        a_hs;
  logic        b_hs;
  logic        src_b;
  logic [31:0] busy;
  logic [31:0] busy_next;

`ifdef WBARB_AGING_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;

  // Counts consecutive cycles B has been valid but refused.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wait_cnt <= 4'd0;
    end else if (!i_b_valid || b_hs) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign b_force = (wait_cnt >= MAX_WAIT_C);
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT > 0);
  assign b_force         = 1'b0;
`endif

  // A wins ties unless B has aged out; the two readies are never both
  // effective in the same cycle.
  assign o_b_ready = i_b_valid & (~i_a_valid | b_force);
  assign o_a_ready = ~(i_b_valid & b_force);

  assign b_hs = i_b_valid & o_b_ready;
  assign a_hs = i_a_valid & o_a_ready & ~b_hs;

  // Output register; address/data hold when idle, x0 writes never enable.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rd_addr <= 5'd0;
      o_rd_data <= 32'd0;
      o_rd_wren <= 1'b0;
      src_b     <= 1'b0;
    end else begin
      o_rd_wren <= 1'b0;
      if (b_hs) begin
        o_rd_addr <= i_b_rd;
        o_rd_data <= i_b_data;
        o_rd_wren <= (i_b_rd != 5'd0);
        src_b     <= 1'b1;
      end else if (a_hs) begin
        o_rd_addr <= i_a_rd;
        o_rd_data <= i_a_data;
        o_rd_wren <= (i_a_rd != 5'd0);
        src_b     <= 1'b0;
      end
    end
  end

  // The clear happens on the edge where the regfile captures the B write;
  // an issue to the same rd on that edge is applied last so it wins.
  always_comb begin
    busy_next = busy;
    if (o_rd_wren && src_b) begin
      busy_next[o_rd_addr] = 1'b0;
    end
    if (i_issue_valid && (i_issue_rd != 5'd0)) begin
      busy_next[i_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

  assign o_busy_vec = {busy[31:1], 1'b0};
  assign o_rs1_busy = o_busy_vec[i_rs1_addr];
  assign o_rs2_busy = o_busy_vec[i_rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  localparam int MAX_WAIT = 4;
`ifdef WBARB_AGING_EN
  localparam bit AGING = 1'b1;
  localparam int AGED_GRANT_CYCLE = MAX_WAIT;
`else
  localparam bit AGING = 1'b0;
  localparam int AGED_GRANT_CYCLE = -1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] busy_vec;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wren;

  int errors = 0;
  int checks = 0;

  // Reference model state: the pending regfile write, the set of busy
  // registers and how long the current B request has been refused.
  logic        m_wren;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_from_b;
  logic [31:0] m_busy;
  int          m_wait;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_a_valid    (a_valid),
    .i_a_rd       (a_rd),
    .i_a_data     (a_data),
    .o_a_ready    (a_ready),
    .i_b_valid    (b_valid),
    .i_b_rd       (b_rd),
    .i_b_data     (b_data),
    .o_b_ready    (b_ready),
    .i_issue_valid(issue_valid),
    .i_issue_rd   (issue_rd),
    .i_rs1_addr   (rs1),
    .i_rs2_addr   (rs2),
    .o_rs1_busy   (rs1_busy),
    .o_rs2_busy   (rs2_busy),
    .o_busy_vec   (busy_vec),
    .o_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_wren    (rd_wren)
  );

  function automatic bit model_forced();
    return AGING && (m_wait >= MAX_WAIT);
  endfunction

  function automatic bit model_b_wins();
    return b_valid && (!a_valid || model_forced());
  endfunction

  function automatic bit model_a_ready();
    return !(b_valid && model_forced());
  endfunction

  task automatic model_reset();
    m_wren   = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_from_b = 1'b0;
    m_busy   = '0;
    m_wait   = 0;
  endtask

  task automatic clear_inputs();
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit          b_go, a_go;
    logic [31:0] nb;
    b_go = model_b_wins();
    a_go = a_valid && model_a_ready() && !b_go;
    nb = m_busy;
    if (m_wren && m_from_b) nb[m_addr] = 1'b0;
    if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
    m_busy = nb;
    if (!b_valid || b_go) m_wait = 0;
    else if (m_wait < 15) m_wait = m_wait + 1;
    if (b_go) begin
      m_wren = (b_rd != 0); m_addr = b_rd; m_data = b_data; m_from_b = 1'b1;
    end else if (a_go) begin
      m_wren = (a_rd != 0); m_addr = a_rd; m_data = a_data; m_from_b = 1'b0;
    end else begin
      m_wren = 1'b0;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    clear_inputs();
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    issue_valid = 1'b1; issue_rd = 5'd9;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hDEAD_BEEF;
    tick();
    clear_inputs();
    rs1 = 5'd9;
    #1;
    checks++;
    if (rd_wren !== 1'b1) begin errors++; $display("FAIL reset_pre_wren got=%b exp=1", rd_wren); end
    checks++;
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got=%b exp=1", rs1_busy); end
    a_valid = 1'b1; b_valid = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if ({rd_wren, rd_addr, rd_data} !== 38'd0) begin
      errors++; $display("FAIL reset_out got wren=%b addr=%0d data=%h exp all 0", rd_wren, rd_addr, rd_data);
    end
    checks++;
    if (busy_vec !== 32'd0 || rs1_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got vec=%h rs1=%b exp 0", busy_vec, rs1_busy);
    end
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got=%b exp=1", a_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (rd_wren !== 1'b0) begin errors++; $display("FAIL reset_hold_wren got=%b exp=0", rd_wren); end
    clear_inputs();
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_simultaneous();
    reset_dut();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h22;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++; $display("FAIL sim_grant got a=%b b=%b exp a=1 b=0", a_ready, b_ready);
    end
    tick();
    a_valid = 1'b0;
    #1;
    checks++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL sim_b_next got=%b exp=1", b_ready); end
    checks++;
    if ({rd_wren, rd_addr, rd_data} !== {1'b1, 5'd5, 32'h11}) begin
      errors++; $display("FAIL sim_a_write got wren=%b addr=%0d data=%h exp 1/5/11", rd_wren, rd_addr, rd_data);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({rd_wren, rd_addr, rd_data} !== {1'b1, 5'd6, 32'h22}) begin
      errors++; $display("FAIL sim_b_write got wren=%b addr=%0d data=%h exp 1/6/22", rd_wren, rd_addr, rd_data);
    end
    tick();
  endtask

  task automatic test_aging();
    bit exp_b;
    reset_dut();
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA0;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'hB0;
    for (int c = 0; c < 8; c++) begin
      a_data = 32'hA0 + 32'(c);
      #1;
      exp_b = (c == AGED_GRANT_CYCLE);
      checks++;
      if (b_ready !== exp_b || a_ready !== !exp_b) begin
        errors++; $display("FAIL aging_c%0d got a=%b b=%b exp a=%b b=%b", c, a_ready, b_ready, !exp_b, exp_b);
      end
      tick();
      if (exp_b) b_data = 32'hB1;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    reset_dut();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    clear_inputs();
    rs1 = 5'd7;
    #1;
    checks++;
    if (busy_vec[7] !== 1'b1) begin errors++; $display("FAIL sb_set got=%b exp=1", busy_vec[7]); end
    tick();
    tick();
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h7777;
    #1;
    checks++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL sb_b_grant got=%b exp=1", b_ready); end
    tick();
    b_valid = 1'b0;
    #1;
    checks++;
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_n1 got=%b exp=1", rs1_busy); end
    tick();
    checks++;
    if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_busy_n2 got=%b exp=0", rs1_busy); end
  endtask

  task automatic test_same_edge();
    reset_dut();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0707;
    tick();
    b_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    checks++;
    if ({rd_wren, rd_addr} !== {1'b1, 5'd7}) begin
      errors++; $display("FAIL same_pending got wren=%b addr=%0d exp 1/7", rd_wren, rd_addr);
    end
    tick();
    issue_valid = 1'b0;
    #1;
    checks++;
    if (busy_vec[7] !== 1'b1) begin errors++; $display("FAIL same_edge_busy got=%b exp=1", busy_vec[7]); end
    tick();
    checks++;
    if (busy_vec[7] !== 1'b1) begin errors++; $display("FAIL same_edge_hold got=%b exp=1", busy_vec[7]); end
  endtask

  task automatic test_x0();
    reset_dut();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_a_ready got=%b exp=1", a_ready); end
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({rd_wren, rd_addr, rd_data} !== {1'b0, 5'd0, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL x0_write got wren=%b addr=%0d data=%h exp 0/0/ffffffff", rd_wren, rd_addr, rd_data);
    end
    checks++;
    if (busy_vec !== 32'd0) begin errors++; $display("FAIL x0_busy got=%h exp=0", busy_vec); end
  endtask

  task automatic test_random();
    bit b_go;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      a_rd = 5'($urandom_range(0, 31));
      a_data = $urandom;
      if (!b_valid || b_ready) begin
        b_valid = ($urandom_range(0, 1) == 1);
        b_rd = 5'($urandom_range(0, 31));
        b_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      #1;
      b_go = model_b_wins();
      checks++;
      if (a_ready !== model_a_ready() || b_ready !== b_go) begin
        errors++; $display("FAIL rnd_ready c=%0d got a=%b b=%b exp a=%b b=%b", c, a_ready, b_ready, model_a_ready(), b_go);
      end
      checks++;
      if (rd_wren !== m_wren || rd_addr !== m_addr || rd_data !== m_data) begin
        errors++; $display("FAIL rnd_out c=%0d got %b/%0d/%h exp %b/%0d/%h", c, rd_wren, rd_addr, rd_data, m_wren, m_addr, m_data);
      end
      checks++;
      if (busy_vec !== m_busy || rs1_busy !== m_busy[rs1] || rs2_busy !== m_busy[rs2]) begin
        errors++; $display("FAIL rnd_busy c=%0d got %h/%b/%b exp %h/%b/%b", c, busy_vec, rs1_busy, rs2_busy, m_busy, m_busy[rs1], m_busy[rs2]);
      end
      tick();
      if (b_go) b_valid = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_simultaneous();
    test_aging();
    test_scoreboard();
    test_same_edge();
    test_x0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
